// File: rtl/freq_sweep_scheduler.sv
// Steps a DDS tuning word from start to stop with a per-point dwell and a valid/ack handoff.
// Optional build macro SWEEP_TRIANGLE_EN: continuous sweeps reverse at the end point instead of restarting.
module freq_sweep_scheduler #(
    parameter int FREQ_W  = 23,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               freq_ack,
    output logic [FREQ_W-1:0]  freq_out,
    output logic               freq_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DWELL = 2'd2,
        STEP  = 2'd3
    } state_t;

    localparam logic [FREQ_W-1:0]  ZERO_F = {FREQ_W{1'b0}};
    localparam logic [FREQ_W-1:0]  ONE_F  = {{(FREQ_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] ZERO_D = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] ONE_D  = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [FREQ_W-1:0]  freq_r;
    logic [FREQ_W-1:0]  start_r;
    logic [FREQ_W-1:0]  stop_r;
    logic [FREQ_W-1:0]  step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] cnt_r;
    logic               cont_r;
    logic               up_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic [FREQ_W-1:0]  next_s;

    // One step toward lim, widened by a bit so wrap-around is caught and clamped to lim.
    function automatic logic [FREQ_W-1:0] next_word(
        input logic [FREQ_W-1:0] cur,
        input logic [FREQ_W-1:0] step,
        input logic [FREQ_W-1:0] lim,
        input logic              up
    );
        logic [FREQ_W:0]   wide;
        logic [FREQ_W-1:0] res;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, step};
            if (wide[FREQ_W] || (wide[FREQ_W-1:0] > lim)) begin
                res = lim;
            end else begin
                res = wide[FREQ_W-1:0];
            end
        end else begin
            wide = {1'b0, cur} - {1'b0, step};
            if (wide[FREQ_W] || (wide[FREQ_W-1:0] < lim)) begin
                res = lim;
            end else begin
                res = wide[FREQ_W-1:0];
            end
        end
        return res;
    endfunction

    assign next_s = next_word(freq_r, step_r, stop_r, up_r);

`ifdef SWEEP_TRIANGLE_EN
    logic [FREQ_W-1:0] turn_s;
    // First word of the return leg: leave the end point heading back to the old start.
    assign turn_s = next_word(stop_r, step_r, start_r, ~up_r);
`endif

    // Sweep sequencer: state, shadow copies of the programming and all outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            freq_r  <= ZERO_F;
            start_r <= ZERO_F;
            stop_r  <= ZERO_F;
            step_r  <= ONE_F;
            dwell_r <= ONE_D;
            cnt_r   <= ZERO_D;
            cont_r  <= 1'b0;
            up_r    <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort) begin
                state_r <= IDLE;
                valid_r <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            start_r <= f_start;
                            stop_r  <= f_stop;
                            step_r  <= (f_step == ZERO_F) ? ONE_F : f_step;
                            dwell_r <= (dwell == ZERO_D) ? ONE_D : dwell;
                            cont_r  <= cont;
                            up_r    <= (f_stop >= f_start);
                            freq_r  <= f_start;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b1;
                            state_r <= ISSUE;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    ISSUE: begin
                        if (freq_ack) begin
                            valid_r <= 1'b0;
                            cnt_r   <= dwell_r;
                            state_r <= DWELL;
                        end else begin
                            state_r <= ISSUE;
                        end
                    end
                    DWELL: begin
                        if (cnt_r <= ONE_D) begin
                            state_r <= STEP;
                        end else begin
                            cnt_r <= cnt_r - ONE_D;
                        end
                    end
                    STEP: begin
                        if (freq_r == stop_r) begin
                            if (cont_r) begin
`ifdef SWEEP_TRIANGLE_EN
                                start_r <= stop_r;
                                stop_r  <= start_r;
                                up_r    <= ~up_r;
                                freq_r  <= turn_s;
`else
                                freq_r  <= start_r;
`endif
                                valid_r <= 1'b1;
                                state_r <= ISSUE;
                            end else begin
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= IDLE;
                            end
                        end else begin
                            freq_r  <= next_s;
                            valid_r <= 1'b1;
                            state_r <= ISSUE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign freq_out   = freq_r;
    assign freq_valid = valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_freq_sweep_scheduler.sv
// Directed bench for freq_sweep_scheduler: expected tuning words queue up at start and are
// popped as each word is offered; timing, clamping, continuous mode, abort and reset are checked.
module tb_freq_sweep_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        cont;
    logic [22:0] f_start;
    logic [22:0] f_stop;
    logic [22:0] f_step;
    logic [15:0] dwell;
    logic        freq_ack;
    logic [22:0] freq_out;
    logic        freq_valid;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [22:0] exp_q[$];

    freq_sweep_scheduler #(.FREQ_W(23), .DWELL_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .cont(cont),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .freq_ack(freq_ack), .freq_out(freq_out), .freq_valid(freq_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [22:0] fs, input logic [22:0] fe, input logic [22:0] st,
                          input logic [15:0] dw, input logic c);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw; cont = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    // Wait (bounded) for an offered word, score it, then ack after 'delay' cycles.
    task automatic serve(input int delay, output int at);
        int n;
        logic [22:0] e;
        n = 0;
        while (freq_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("valid_wait", 32'(n < 100), 32'd1);
        at = cyc;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 23'h7FFFFF;
        chk("freq_out", freq_out, e);
        repeat (delay) tick();
        freq_ack = 1'b1;
        tick();
        freq_ack = 1'b0;
        chk("valid_drop", freq_valid, 1'b0);
    endtask

    // Entered one cycle after the final ack; done must rise dw_eff+1 cycles later.
    task automatic finish_check(input int dw_eff, input int pulses);
        repeat (dw_eff + 1) tick();
        chk("done_pulse", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        tick();
        chk("done_clear", done, 1'b0);
        chk("done_count", done_cnt, pulses);
    endtask

    initial begin
        int at;
        int prev;
        int stable;
        logic [22:0] last;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0; freq_ack = 1'b0;
        f_start = 23'd0; f_stop = 23'd0; f_step = 23'd0; dwell = 16'd0;
        repeat (3) tick();
        chk("rst_freq_out", freq_out, 23'd0);
        chk("rst_valid", freq_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset_n = 1'b1;
        tick();

        // Upward sweep, ack one cycle after each offer.
        exp_q.push_back(23'd100); exp_q.push_back(23'd110);
        exp_q.push_back(23'd120); exp_q.push_back(23'd130);
        launch(23'd100, 23'd130, 23'd10, 16'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            prev = at;
            serve(1, at);
            if (i > 0) chk("spacing_up", at - prev, 6);
        end
        finish_check(3, 1);
        chk("hold_after_done", freq_out, 23'd130);

        // Downward sweep with final-point clamp.
        exp_q.push_back(23'd130); exp_q.push_back(23'd118);
        exp_q.push_back(23'd106); exp_q.push_back(23'd100);
        launch(23'd130, 23'd100, 23'd12, 16'd1, 1'b0);
        for (int i = 0; i < 4; i++) serve(0, at);
        finish_check(1, 2);

        // Overflow clamp near the top of the range.
        exp_q.push_back(23'h7FFF00); exp_q.push_back(23'h7FFFF0);
        launch(23'h7FFF00, 23'h7FFFF0, 23'h7FFFFF, 16'd2, 1'b0);
        for (int i = 0; i < 2; i++) serve(1, at);
        finish_check(2, 3);

        // Zero step and zero dwell behave as one.
        for (int i = 0; i < 4; i++) exp_q.push_back(23'd50 + 23'(i));
        launch(23'd50, 23'd53, 23'd0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            prev = at;
            serve(0, at);
            if (i > 0) chk("spacing_min", at - prev, 3);
        end
        finish_check(1, 4);

        // Overshoot without overflow clamps to stop.
        exp_q.push_back(23'd5); exp_q.push_back(23'd12);
        exp_q.push_back(23'd19); exp_q.push_back(23'd20);
        launch(23'd5, 23'd20, 23'd7, 16'd1, 1'b0);
        for (int i = 0; i < 4; i++) serve(0, at);
        finish_check(1, 5);

        // Ack withheld: word must stay offered; start and new inputs while busy ignored.
        exp_q.push_back(23'd200); exp_q.push_back(23'd210);
        launch(23'd200, 23'd210, 23'd10, 16'd1, 1'b0);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                f_start = 23'd999; f_stop = 23'd5; f_step = 23'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (freq_valid === 1'b1 && freq_out === 23'd200) stable++;
        end
        start = 1'b0;
        chk("hold_stable", stable, 20);
        for (int i = 0; i < 2; i++) serve(0, at);
        finish_check(1, 6);

        // Continuous sweep, then abort mid-dwell.
        exp_q.push_back(23'd100); exp_q.push_back(23'd110); exp_q.push_back(23'd120);
`ifdef SWEEP_TRIANGLE_EN
        exp_q.push_back(23'd110); exp_q.push_back(23'd100);
        exp_q.push_back(23'd110); exp_q.push_back(23'd120);
        last = 23'd120;
`else
        exp_q.push_back(23'd100); exp_q.push_back(23'd110);
        exp_q.push_back(23'd120); exp_q.push_back(23'd100);
        last = 23'd100;
`endif
        launch(23'd100, 23'd120, 23'd10, 16'd4, 1'b1);
        for (int i = 0; i < 7; i++) serve(0, at);
        chk("cont_busy", busy, 1'b1);
        chk("cont_no_done", done_cnt, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", freq_valid, 1'b0);
        chk("abort_hold", freq_out, last);
        repeat (10) tick();
        chk("abort_idle", freq_valid, 1'b0);
        chk("abort_no_done", done_cnt, 6);

        // Start and abort together in IDLE: abort wins.
        f_start = 23'd400; f_stop = 23'd500; cont = 1'b0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_valid", freq_valid, 1'b0);

        // Asynchronous reset while a word is offered.
        launch(23'd300, 23'd400, 23'd50, 16'd1, 1'b0);
        chk("pre_reset_valid", freq_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_freq_out", freq_out, 23'd0);
        chk("areset_valid", freq_valid, 1'b0);
        chk("areset_busy", busy, 1'b0);
        chk("areset_done", done, 1'b0);
        exp_q.delete();
        reset_n = 1'b1;
        tick();
        chk("post_reset_idle", busy, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_sweep_scheduler.md
# freq_sweep_scheduler

Sequences the 23-bit DDS tuning word through a programmed frequency sweep, from a start word to a stop word in fixed steps with a programmable dwell per point. It sits between the front-panel/parameter logic and the waveform generator, replacing manual increase/decrease stepping when a sweep is armed. Each new word is handed to the generator over a valid/ack handshake.

## Interface
- FREQ_W, 23, tuning-word width
- DWELL_W, 16, dwell counter width (cycles per point)
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level sampled each cycle; in IDLE, high launches a sweep
- abort  in  1  high forces IDLE next cycle from any state
- cont  in  1  repeat sweep continuously (latched at start)
- f_start  in  FREQ_W  first tuning word
- f_stop  in  FREQ_W  last tuning word
- f_step  in  FREQ_W  step magnitude, unsigned
- dwell  in  DWELL_W  cycles to hold each point after ack
- freq_ack  in  1  generator accepted freq_out
- freq_out  out  FREQ_W  current tuning word
- freq_valid  out  1  freq_out is new, held until ack
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at normal sweep completion

## Operation
- States: IDLE, ISSUE, DWELL, STEP.
- IDLE: start=1 latches f_start, f_stop, f_step, dwell, cont into shadow registers; freq_out<=f_start; -> ISSUE. Input changes after this are ignored until next IDLE.
- Direction latched: up if f_stop >= f_start, else down.
- f_step=0 treated as 1; dwell=0 treated as 1.
- ISSUE: freq_valid=1; on freq_ack=1 -> DWELL, dwell counter loaded.
- DWELL: counter decrements; when it would reach 0 -> STEP.
- STEP: if freq_out == stop: cont=0 -> pulse done, -> IDLE; cont=1 -> restart (see Configuration) and -> ISSUE. Else next = freq_out ± step computed at FREQ_W+1 bits; if next passes stop or overflows/underflows, next = stop; -> ISSUE.
- f_start == f_stop: single point issued, then done (or re-issued forever if cont).
- abort: highest priority; -> IDLE, freq_valid and busy low next cycle, no done pulse; freq_out holds last value.
- start while busy is ignored; start and abort in same IDLE cycle: abort wins, stay IDLE.
- freq_out holds its value in IDLE after completion.

## Timing
- Reset: freq_out=0, freq_valid=0, busy=0, done=0, state IDLE; reset mid-sweep discards the sweep immediately.
- start high at cycle N (IDLE): freq_out=f_start, freq_valid=1, busy=1 at N+1.
- freq_ack sampled at cycle A with freq_valid=1: freq_valid=0 at A+1; next freq_valid=1 at A+dwell+2 (one STEP cycle).
- freq_ack while freq_valid=0 is ignored.
- Final point: done=1 at A+dwell+2 for one cycle, busy=0 same cycle.
- abort at cycle N: busy=0, freq_valid=0 at N+1.

## Configuration
- SWEEP_TRIANGLE_EN defined: in cont mode, at stop the shadow start/stop are swapped and direction reversed; the stop point is not re-issued, the next word is stop ∓ step (triangle sweep; same clamping).
- Undefined: in cont mode, at stop the next issued word is the original f_start (sawtooth sweep).
- Non-cont behaviour identical in both builds.

## Test plan
- f_start=100, f_stop=130, f_step=10, dwell=3, ack one cycle after each valid -> freq_out sequence 100,110,120,130; valid-to-valid spacing 6 cycles; single done pulse; busy low after.
- f_start=130, f_stop=100, f_step=12 -> sequence 130,118,106,100 (clamped); done pulse.
- f_stop=0x7FFFF0, f_step=0x7FFFFF -> second word clamped to 0x7FFFF0, no wrap; f_step=0, dwell=0 -> steps of 1, 3-cycle spacing.
- Hold freq_ack low 20 cycles -> freq_valid and freq_out stable 20 cycles; no advance.
- cont=1, 100->120 step 10 -> without SWEEP_TRIANGLE_EN: 100,110,120,100,...; with: 100,110,120,110,100,110,...; never done.
- abort mid-DWELL -> busy=0 next cycle, no done; reset_n low mid-ISSUE -> all outputs 0 asynchronously; start during busy ignored.
